// File: rtl/lm07_spi_display.sv
// lm07_spi_display
// Periodically reads a temperature frame from an SPI sensor, extracts the
// signed integer-degree field and drives a multiplexed 7-segment display
// in decimal mode (sign, leading-zero blanking, overflow) or raw-hex mode.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ena               enables the sample timer (0 clears it)
//   mode_hex          0 = decimal, 1 = raw hex of the low nibbles of the frame
//   hold              1 = suppress new transaction starts
//   spi_cs_n, spi_sck sensor chip select (active-low) and clock (idle low)
//   spi_sdi           sensor data, sampled MSB-first on sck rising
//   seg               segments {g,f,e,d,c,b,a}, active-high
//   dig_sel           one-hot digit enable, bit0 = least-significant digit
//   temp_raw          last completed frame
//   valid             one-cycle pulse when temp_raw/display update
//   busy              high from transaction start until conversion done
//
// state   | meaning
// IDLE    | waiting for a sample tick
// SETUP   | cs_n low, sck low, CLK_DIV cycles before the first edge
// SHIFT   | FRAME_BITS sck periods, sdi sampled on each rising edge
// FINISH  | sck low, cs_n still low for CLK_DIV cycles
// CONVERT | double-dabble of |v| into BCD, then publish frame and digits
module lm07_spi_display #(
   parameter int CLK_DIV       = 4,
   parameter int FRAME_BITS    = 16,
   parameter int INT_MSB       = 15,
   parameter int INT_LSB       = 7,
   parameter int NUM_DIGITS    = 3,
   parameter int SAMPLE_PERIOD = 1000000,
   parameter int REFRESH_DIV   = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  mode_hex,
   input  logic                  hold,
   output logic                  spi_cs_n,
   output logic                  spi_sck,
   input  logic                  spi_sdi,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] dig_sel,
   output logic [FRAME_BITS-1:0] temp_raw,
   output logic                  valid,
   output logic                  busy
);

   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   localparam int W     = INT_MSB - INT_LSB + 1;
   localparam int SMP_W = $clog2(SAMPLE_PERIOD + 1);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = $clog2(FRAME_BITS + 1);
   localparam int REF_W = $clog2(REFRESH_DIV + 1);
   localparam logic [31:0] LIM_POS = 32'(pow10(NUM_DIGITS) - 1);
   localparam logic [31:0] LIM_NEG = 32'(pow10(NUM_DIGITS - 1) - 1);
   localparam logic [6:0]  SEG_DASH = 7'h40;
   localparam logic [6:0]  SEG_E    = 7'h79;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_FINISH, S_CONVERT} state_t;

   state_t                            state, state_nxt;
   logic [SMP_W-1:0]                  smp_cnt;
   logic                              smp_tick;
   logic [DIV_W-1:0]                  div_cnt, div_nxt;
   logic                              sck_half, half_nxt;
   logic [BIT_W-1:0]                  bit_cnt, bit_nxt;
   logic [FRAME_BITS-1:0]             shreg, sh_nxt;
   logic [W-1:0]                      conv_bin, bin_nxt;
   logic [W-1:0]                      conv_mag, mag_nxt;
   logic                              conv_neg, neg_nxt;
   logic [15:0]                       conv_bcd, bcd_nxt, bcd_adj;
   logic [3:0]                        conv_cnt, ccnt_nxt;
   logic [FRAME_BITS-1:0]             raw_nxt;
   logic [NUM_DIGITS-1:0][6:0]        disp_dec, disp_nxt, dec_seg;
   logic                              disp_vld, dvld_nxt;
   logic                              valid_nxt;
   logic [W-1:0]                      fld;
   logic [3:0]                        sig;
   logic                              ovf;
   logic [REF_W-1:0]                  ref_cnt;
   logic [1:0]                        dig_idx;
   logic [6:0]                        dec_cur;
   logic [3:0]                        nib;

   // Sample timer: a dropped tick is simply lost, nothing is queued.
   assign smp_tick = ena && (smp_cnt == SMP_W'(SAMPLE_PERIOD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         smp_cnt <= '0;
      end else if (!ena || smp_tick) begin
         smp_cnt <= '0;
      end else begin
         smp_cnt <= smp_cnt + SMP_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         div_cnt  <= '0;
         sck_half <= 1'b0;
         bit_cnt  <= '0;
         shreg    <= '0;
         conv_bin <= '0;
         conv_mag <= '0;
         conv_neg <= 1'b0;
         conv_bcd <= '0;
         conv_cnt <= '0;
         temp_raw <= '0;
         disp_dec <= '0;
         disp_vld <= 1'b0;
         valid    <= 1'b0;
         spi_cs_n <= 1'b1;
         spi_sck  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         div_cnt  <= div_nxt;
         sck_half <= half_nxt;
         bit_cnt  <= bit_nxt;
         shreg    <= sh_nxt;
         conv_bin <= bin_nxt;
         conv_mag <= mag_nxt;
         conv_neg <= neg_nxt;
         conv_bcd <= bcd_nxt;
         conv_cnt <= ccnt_nxt;
         temp_raw <= raw_nxt;
         disp_dec <= disp_nxt;
         disp_vld <= dvld_nxt;
         valid    <= valid_nxt;
         // Pins are registered from next-state so they never glitch on
         // multi-bit state changes.
         spi_cs_n <= !(state_nxt inside {S_SETUP, S_SHIFT, S_FINISH});
         spi_sck  <= (state_nxt == S_SHIFT) && half_nxt;
         busy     <= (state_nxt != S_IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      half_nxt  = sck_half;
      bit_nxt   = bit_cnt;
      sh_nxt    = shreg;
      bin_nxt   = conv_bin;
      mag_nxt   = conv_mag;
      neg_nxt   = conv_neg;
      bcd_nxt   = conv_bcd;
      ccnt_nxt  = conv_cnt;
      raw_nxt   = temp_raw;
      disp_nxt  = disp_dec;
      dvld_nxt  = disp_vld;
      valid_nxt = 1'b0;
      fld       = '0;
      bcd_adj   = conv_bcd;
      case (state)
         S_IDLE: begin
            if (smp_tick && !hold) begin
               state_nxt = S_SETUP;
               div_nxt   = DIV_W'(CLK_DIV - 1);
            end
         end
         S_SETUP: begin
            if (div_cnt == '0) begin
               state_nxt = S_SHIFT;
               div_nxt   = DIV_W'(CLK_DIV - 1);
               half_nxt  = 1'b0;
               bit_nxt   = BIT_W'(FRAME_BITS - 1);
            end else begin
               div_nxt = div_cnt - DIV_W'(1);
            end
         end
         S_SHIFT: begin
            if (div_cnt != '0) begin
               div_nxt = div_cnt - DIV_W'(1);
            end else begin
               div_nxt = DIV_W'(CLK_DIV - 1);
               if (!sck_half) begin
                  // This edge raises sck; capture sdi on the same edge.
                  half_nxt = 1'b1;
                  sh_nxt   = {shreg[FRAME_BITS-2:0], spi_sdi};
               end else begin
                  half_nxt = 1'b0;
                  if (bit_cnt == '0) begin
                     state_nxt = S_FINISH;
                  end else begin
                     bit_nxt = bit_cnt - BIT_W'(1);
                  end
               end
            end
         end
         S_FINISH: begin
            if (div_cnt == '0) begin
               state_nxt = S_CONVERT;
               fld       = shreg[INT_MSB:INT_LSB];
               neg_nxt   = fld[W-1];
               // |v| fits in W unsigned bits even for the most negative value.
               mag_nxt   = fld[W-1] ? -fld : fld;
               bin_nxt   = fld[W-1] ? -fld : fld;
               bcd_nxt   = '0;
               ccnt_nxt  = 4'(W);
            end else begin
               div_nxt = div_cnt - DIV_W'(1);
            end
         end
         S_CONVERT: begin
            if (conv_cnt != 4'd0) begin
               for (int d = 0; d < 4; d++) begin
                  if (bcd_adj[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_adj[4*d +: 4] + 4'd3;
               end
               bcd_nxt  = {bcd_adj[14:0], conv_bin[W-1]};
               bin_nxt  = conv_bin << 1;
               ccnt_nxt = conv_cnt - 4'd1;
            end else begin
               state_nxt = S_IDLE;
               raw_nxt   = shreg;
               disp_nxt  = dec_seg;
               dvld_nxt  = 1'b1;
               valid_nxt = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Decimal encoding of the finished conversion. sig[k] = some digit at
   // position k or above is non-zero.
   always_comb begin
      sig[3] = (conv_bcd[15:12] != 4'd0);
      for (int d = 2; d >= 0; d--) sig[d] = sig[d+1] | (conv_bcd[4*d +: 4] != 4'd0);
      ovf = conv_neg ? (32'(conv_mag) > LIM_NEG) : (32'(conv_mag) > LIM_POS);
      dec_seg = '0;
      if (ovf) begin
         for (int k = 0; k < NUM_DIGITS; k++) dec_seg[k] = SEG_DASH;
         dec_seg[NUM_DIGITS-1] = SEG_E;
      end else begin
         dec_seg[0] = seg7(conv_bcd[3:0]);
         for (int k = 1; k < NUM_DIGITS; k++) begin
            if (sig[k])                     dec_seg[k] = seg7(conv_bcd[4*k +: 4]);
            else if (conv_neg && sig[k-1])  dec_seg[k] = SEG_DASH;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_cnt <= REF_W'(REFRESH_DIV - 1);
         dig_idx <= 2'd0;
      end else if (ref_cnt == '0) begin
         ref_cnt <= REF_W'(REFRESH_DIV - 1);
         dig_idx <= (dig_idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : dig_idx + 2'd1;
      end else begin
         ref_cnt <= ref_cnt - REF_W'(1);
      end
   end

   // seg is decoded from the digit index register, so seg and dig_sel
   // switch on the same edge and mode_hex applies without a new frame.
   always_comb begin
      dec_cur = '0;
      nib     = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (dig_idx == 2'(k)) begin
            dec_cur = disp_dec[k];
            nib     = temp_raw[4*k +: 4];
         end
      end
      if (!disp_vld)     seg = 7'h00;
      else if (mode_hex) seg = seg7(nib);
      else               seg = dec_cur;
      dig_sel = NUM_DIGITS'(1) << dig_idx;
   end

endmodule

// File: tb/tb_lm07_spi_display.sv
module tb_lm07_spi_display;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic        mode_hex;
   logic        hold;
   logic        spi_cs_n;
   logic        spi_sck;
   logic        spi_sdi;
   logic [6:0]  seg;
   logic [2:0]  dig_sel;
   logic [15:0] temp_raw;
   logic        valid;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;
   int rise_cnt = 0;
   int fall_cnt = 0;
   int fall_base = 0;
   int cs_low_cnt = 0;
   int cs_fall_cnt = 0;
   int valid_cnt = 0;
   int sdi_idx;
   logic [15:0] frame_tx = 16'h0000;

   lm07_spi_display #(
      .CLK_DIV(2), .FRAME_BITS(16), .INT_MSB(15), .INT_LSB(7),
      .NUM_DIGITS(3), .SAMPLE_PERIOD(200), .REFRESH_DIV(3)
   ) dut (
      .clk(clk), .rst(rst), .ena(ena), .mode_hex(mode_hex), .hold(hold),
      .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
      .seg(seg), .dig_sel(dig_sel), .temp_raw(temp_raw),
      .valid(valid), .busy(busy)
   );

   always #5 clk = ~clk;

   // Sensor model: MSB presented when cs_n falls, next bit after each sck fall.
   always @(negedge spi_sck) fall_cnt++;
   always @(negedge spi_cs_n) begin
      fall_base = fall_cnt;
      cs_fall_cnt++;
   end
   assign sdi_idx = 15 - (fall_cnt - fall_base);
   assign spi_sdi = (sdi_idx >= 0 && sdi_idx < 16) ? frame_tx[sdi_idx[3:0]] : 1'b0;

   always @(posedge spi_sck) rise_cnt++;
   always @(posedge clk) begin
      if (spi_cs_n === 1'b0) cs_low_cnt++;
      if (valid === 1'b1)    valid_cnt++;
   end

   task automatic clear_counts();
      rise_cnt = 0; cs_low_cnt = 0; cs_fall_cnt = 0; valid_cnt = 0;
   endtask

   task automatic wait_valid(input int budget);
      bit got = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (valid === 1'b1) begin got = 1; break; end
      end
      if (!got) begin
         n_assert++; n_fail++;
         $display("FAIL valid_timeout: no valid pulse within %0d cycles", budget);
      end
   endtask

   task automatic get_digit(input int k, output logic [6:0] s);
      logic [2:0] want;
      bit got = 0;
      want = 3'(1 << k);
      s = 'x;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dig_sel === want) begin s = seg; got = 1; break; end
      end
      if (!got) begin
         n_assert++; n_fail++;
         $display("FAIL digit_timeout: digit %0d never selected", k);
      end
   endtask

   task automatic test_reset();
      n_assert++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n: got %b want 1", spi_cs_n); end
      n_assert++; if (spi_sck !== 1'b0) begin n_fail++; $display("FAIL rst_sck: got %b want 0", spi_sck); end
      n_assert++; if (temp_raw !== 16'h0) begin n_fail++; $display("FAIL rst_temp_raw: got %h want 0000", temp_raw); end
      n_assert++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid); end
      n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_assert++; if (seg !== 7'h00) begin n_fail++; $display("FAIL rst_seg: got %h want 00", seg); end
      n_assert++; if (dig_sel !== 3'b001) begin n_fail++; $display("FAIL rst_dig_sel: got %b want 001", dig_sel); end
   endtask

   task automatic test_frame_decimal();
      logic [6:0] d;
      logic [6:0] exp_d [3] = '{7'h6D, 7'h5B, 7'h00};
      @(negedge clk);
      frame_tx = 16'h0C80; clear_counts(); ena = 1'b1;
      wait_valid(600);
      n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dec_busy_at_valid: got %b want 0", busy); end
      @(negedge clk);
      ena = 1'b0;
      n_assert++; if (valid !== 1'b0) begin n_fail++; $display("FAIL dec_valid_width: got %b want 0", valid); end
      n_assert++; if (rise_cnt != 16) begin n_fail++; $display("FAIL dec_sck_rises: got %0d want 16", rise_cnt); end
      n_assert++; if (cs_low_cnt != 68) begin n_fail++; $display("FAIL dec_cs_low: got %0d want 68", cs_low_cnt); end
      n_assert++; if (valid_cnt != 1) begin n_fail++; $display("FAIL dec_valid_cnt: got %0d want 1", valid_cnt); end
      n_assert++; if (temp_raw !== 16'h0C80) begin n_fail++; $display("FAIL dec_temp_raw: got %h want 0c80", temp_raw); end
      for (int k = 0; k < 3; k++) begin
         get_digit(k, d);
         n_assert++; if (d !== exp_d[k]) begin n_fail++; $display("FAIL dec_digit%0d: got %h want %h", k, d, exp_d[k]); end
      end
   endtask

   task automatic test_negative_hex();
      logic [6:0] d;
      logic [6:0] exp_dec [3] = '{7'h6D, 7'h40, 7'h00};
      logic [6:0] exp_hex [3] = '{7'h3F, 7'h7F, 7'h5E};
      @(negedge clk);
      frame_tx = 16'hFD80; clear_counts(); ena = 1'b1;
      wait_valid(600);
      @(negedge clk);
      ena = 1'b0;
      for (int k = 0; k < 3; k++) begin
         get_digit(k, d);
         n_assert++; if (d !== exp_dec[k]) begin n_fail++; $display("FAIL neg_digit%0d: got %h want %h", k, d, exp_dec[k]); end
      end
      valid_cnt = 0;
      mode_hex = 1'b1;
      for (int k = 0; k < 3; k++) begin
         get_digit(k, d);
         n_assert++; if (d !== exp_hex[k]) begin n_fail++; $display("FAIL hex_digit%0d: got %h want %h", k, d, exp_hex[k]); end
      end
      n_assert++; if (valid_cnt != 0) begin n_fail++; $display("FAIL hex_no_frame: got %0d valid pulses want 0", valid_cnt); end
      mode_hex = 1'b0;
   endtask

   task automatic test_overflow();
      logic [6:0] d;
      logic [15:0] frames [3] = '{16'h8000, 16'h7F80, 16'h0000};
      logic [6:0]  exp_d [3][3] = '{'{7'h40, 7'h40, 7'h79},
                                     '{7'h6D, 7'h6D, 7'h5B},
                                     '{7'h3F, 7'h00, 7'h00}};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         frame_tx = frames[i]; clear_counts(); ena = 1'b1;
         wait_valid(600);
         @(negedge clk);
         ena = 1'b0;
         n_assert++; if (temp_raw !== frames[i]) begin n_fail++; $display("FAIL ovf_temp_raw%0d: got %h want %h", i, temp_raw, frames[i]); end
         for (int k = 0; k < 3; k++) begin
            get_digit(k, d);
            n_assert++; if (d !== exp_d[i][k]) begin n_fail++; $display("FAIL ovf%0d_digit%0d: got %h want %h", i, k, d, exp_d[i][k]); end
         end
      end
   endtask

   task automatic test_hold_ena();
      logic [6:0] d;
      logic [6:0] exp_d [3] = '{7'h3F, 7'h6D, 7'h00};
      bit reached = 0;
      @(negedge clk);
      clear_counts(); hold = 1'b1; ena = 1'b1;
      repeat (450) @(negedge clk);
      n_assert++; if (cs_fall_cnt != 0) begin n_fail++; $display("FAIL hold_no_start: got %0d cs falls want 0", cs_fall_cnt); end
      n_assert++; if (valid_cnt != 0) begin n_fail++; $display("FAIL hold_no_valid: got %0d want 0", valid_cnt); end
      frame_tx = 16'h1900; clear_counts(); hold = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (rise_cnt >= 4) begin reached = 1; break; end
      end
      n_assert++; if (!reached) begin n_fail++; $display("FAIL hold_shift_timeout: got %0d rises want 4", rise_cnt); end
      hold = 1'b1;
      wait_valid(300);
      @(negedge clk);
      ena = 1'b0;
      n_assert++; if (valid_cnt != 1) begin n_fail++; $display("FAIL hold_mid_valid: got %0d want 1", valid_cnt); end
      n_assert++; if (temp_raw !== 16'h1900) begin n_fail++; $display("FAIL hold_mid_temp_raw: got %h want 1900", temp_raw); end
      for (int k = 0; k < 3; k++) begin
         get_digit(k, d);
         n_assert++; if (d !== exp_d[k]) begin n_fail++; $display("FAIL hold_digit%0d: got %h want %h", k, d, exp_d[k]); end
      end
      hold = 1'b0; clear_counts();
      repeat (450) @(negedge clk);
      n_assert++; if (cs_fall_cnt != 0) begin n_fail++; $display("FAIL ena_off: got %0d cs falls want 0", cs_fall_cnt); end
   endtask

   task automatic test_reset_mid();
      logic [6:0] d;
      logic [6:0] exp_d [3] = '{7'h3F, 7'h5B, 7'h40};
      bit reached = 0;
      @(negedge clk);
      frame_tx = 16'hF600; clear_counts(); ena = 1'b1;
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         if (rise_cnt >= 9) begin reached = 1; break; end
      end
      n_assert++; if (!reached) begin n_fail++; $display("FAIL rmid_timeout: got %0d rises want 9", rise_cnt); end
      rst = 1'b1;
      #1;
      n_assert++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL rmid_cs_n: got %b want 1", spi_cs_n); end
      n_assert++; if (spi_sck !== 1'b0) begin n_fail++; $display("FAIL rmid_sck: got %b want 0", spi_sck); end
      n_assert++; if (temp_raw !== 16'h0) begin n_fail++; $display("FAIL rmid_temp_raw: got %h want 0000", temp_raw); end
      n_assert++; if (seg !== 7'h00) begin n_fail++; $display("FAIL rmid_seg: got %h want 00", seg); end
      repeat (3) @(negedge clk);
      n_assert++; if (valid_cnt != 0) begin n_fail++; $display("FAIL rmid_no_valid: got %0d want 0", valid_cnt); end
      rst = 1'b0; clear_counts();
      wait_valid(600);
      @(negedge clk);
      ena = 1'b0;
      n_assert++; if (rise_cnt != 16) begin n_fail++; $display("FAIL rmid_next_rises: got %0d want 16", rise_cnt); end
      n_assert++; if (valid_cnt != 1) begin n_fail++; $display("FAIL rmid_next_valid: got %0d want 1", valid_cnt); end
      n_assert++; if (temp_raw !== 16'hF600) begin n_fail++; $display("FAIL rmid_next_temp_raw: got %h want f600", temp_raw); end
      for (int k = 0; k < 3; k++) begin
         get_digit(k, d);
         n_assert++; if (d !== exp_d[k]) begin n_fail++; $display("FAIL rmid_digit%0d: got %h want %h", k, d, exp_d[k]); end
      end
   endtask

   task automatic test_refresh();
      logic [6:0] exp_d [3] = '{7'h3F, 7'h5B, 7'h40};
      logic [2:0] want;
      int idx;
      bit sync = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dig_sel === 3'b100) begin sync = 1; break; end
      end
      if (sync) begin
         sync = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dig_sel === 3'b001) begin sync = 1; break; end
         end
      end
      n_assert++; if (!sync) begin n_fail++; $display("FAIL refresh_sync: got %b want 001 after 100", dig_sel); end
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk);
         idx  = (i / 3) % 3;
         want = 3'(1 << idx);
         n_assert++; if (dig_sel !== want) begin n_fail++; $display("FAIL refresh_sel_c%0d: got %b want %b", i, dig_sel, want); end
         n_assert++; if (seg !== exp_d[idx]) begin n_fail++; $display("FAIL refresh_seg_c%0d: got %h want %h", i, seg, exp_d[idx]); end
      end
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0; hold = 1'b0; mode_hex = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      test_frame_decimal();
      test_negative_hex();
      test_overflow();
      test_hold_ena();
      test_reset_mid();
      test_refresh();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
